udp_packet_gate: RTL

Parametrised user-data-path stage that buffers the module-header/packet stream in an input FIFO and forwards, drops or holds whole packets according to a software-set mode. Mode changes take effect only on packet boundaries, so no packet is ever truncated. Sits anywhere in the user data path chain between two modules with the standard data/ctrl/wr/rdy handshake. Passed and dropped packets are counted and exposed on the daisy-chained register ring.

---
 rtl/udp_packet_gate_pkg.sv | 30 +++
 rtl/fallthrough_small_fifo.sv | 56 +++++
 rtl/generic_regs.sv | 87 ++++++++
 rtl/udp_packet_gate.sv | 134 +++++++++++++
 4 files changed

// File: rtl/udp_packet_gate_pkg.sv
// Shared encodings, register map and widths for the packet gate and its register ring.
package udp_packet_gate_pkg;

   localparam int unsigned UdpRegAddrWidth  = 23;
   localparam int unsigned CpciDataWidth    = 32;

   localparam int unsigned GateTag          = 0;
   localparam int unsigned GateRegAddrWidth = 2;

   localparam logic [1:0] ModePass = 2'd0;
   localparam logic [1:0] ModeDrop = 2'd1;
   localparam logic [1:0] ModeHold = 2'd2;

   localparam int unsigned RegMode        = 0;
   localparam int unsigned RegPktsPassed  = 1;
   localparam int unsigned RegPktsDropped = 2;

   typedef enum logic [1:0] {StIdle, StHdr, StPay} state_e;
   typedef enum logic [1:0] {DecPass, DecDrop, DecHold} dec_e;

   // Encoding 3 is reserved and behaves as PASS.
   function automatic dec_e mode_to_dec(input logic [1:0] mode);
      case (mode)
         ModeDrop: return DecDrop;
         ModeHold: return DecHold;
         default:  return DecPass;
      endcase
   endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fall-through FIFO: the head word is visible on dout while not empty.
module fallthrough_small_fifo #(
   parameter int unsigned WIDTH          = 72,
   parameter int unsigned MAX_DEPTH_BITS = 3,
   parameter int unsigned NEARLY_FULL    = 2**MAX_DEPTH_BITS - 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             nearly_full,
   output logic             empty
);

   localparam int unsigned Depth = 2**MAX_DEPTH_BITS;

   logic [WIDTH-1:0]          mem_q [Depth];
   logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
   logic [MAX_DEPTH_BITS:0]   count_q, count_d;
   logic                      full, do_wr, do_rd;

   assign full        = (count_q == (MAX_DEPTH_BITS+1)'(Depth));
   assign empty       = (count_q == '0);
   assign nearly_full = (count_q >= (MAX_DEPTH_BITS+1)'(NEARLY_FULL));
   assign do_wr       = wr_en && !full;
   assign do_rd       = rd_en && !empty;
   assign dout        = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      case ({do_wr, do_rd})
         2'b10:   count_d = count_q + (MAX_DEPTH_BITS+1)'(1);
         2'b01:   count_d = count_q - (MAX_DEPTH_BITS+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/generic_regs.sv
// Register-ring slave: software registers at offset 0.., counters directly after them.
module generic_regs import udp_packet_gate_pkg::*; #(
   parameter int unsigned TAG               = 0,
   parameter int unsigned REG_ADDR_WIDTH    = 2,
   parameter int unsigned REG_SRC_WIDTH     = 2,
   parameter int unsigned NUM_COUNTERS      = 2,
   parameter int unsigned NUM_SOFTWARE_REGS = 1,
   parameter int unsigned NUM_HARDWARE_REGS = 0
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       reg_req_in,
   input  logic                                       reg_ack_in,
   input  logic                                       reg_rd_wr_L_in,
   input  logic [UdpRegAddrWidth-1:0]                 reg_addr_in,
   input  logic [CpciDataWidth-1:0]                   reg_data_in,
   input  logic [REG_SRC_WIDTH-1:0]                   reg_src_in,
   output logic                                       reg_req_out,
   output logic                                       reg_ack_out,
   output logic                                       reg_rd_wr_L_out,
   output logic [UdpRegAddrWidth-1:0]                 reg_addr_out,
   output logic [CpciDataWidth-1:0]                   reg_data_out,
   output logic [REG_SRC_WIDTH-1:0]                   reg_src_out,
   input  logic [NUM_COUNTERS-1:0]                    counter_updates,
   output logic [NUM_SOFTWARE_REGS*CpciDataWidth-1:0] software_regs
);

   localparam int unsigned TagWidth = UdpRegAddrWidth - REG_ADDR_WIDTH;
   localparam logic [TagWidth-1:0] TagBits = TagWidth'(TAG);
   localparam int unsigned NumRegs = NUM_SOFTWARE_REGS + NUM_COUNTERS + NUM_HARDWARE_REGS;

   logic [CpciDataWidth-1:0]  sw_q  [NUM_SOFTWARE_REGS];
   logic [CpciDataWidth-1:0]  cnt_q [NUM_COUNTERS];
   logic [CpciDataWidth-1:0]  rd_val;
   logic [REG_ADDR_WIDTH-1:0] offset;
   logic                      claim;

   assign offset = reg_addr_in[REG_ADDR_WIDTH-1:0];
   // Only claim requests no earlier block on the ring has already acknowledged.
   assign claim  = reg_req_in && !reg_ack_in
                   && (reg_addr_in[UdpRegAddrWidth-1:REG_ADDR_WIDTH] == TagBits);

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < int'(NUM_SOFTWARE_REGS); i++) begin
         if (int'(offset) == i) rd_val = sw_q[i];
      end
      for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
         if (int'(offset) == int'(NUM_SOFTWARE_REGS) + i) rd_val = cnt_q[i];
      end
      if (int'(offset) >= int'(NumRegs)) rd_val = 32'hDEAD_BEEF;
   end

   always_comb begin
      software_regs = '0;
      for (int i = 0; i < int'(NUM_SOFTWARE_REGS); i++) begin
         software_regs[i*CpciDataWidth +: CpciDataWidth] = sw_q[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_req_out     <= 1'b0;
         reg_ack_out     <= 1'b0;
         reg_rd_wr_L_out <= 1'b0;
         reg_addr_out    <= '0;
         reg_data_out    <= '0;
         reg_src_out     <= '0;
         for (int i = 0; i < int'(NUM_SOFTWARE_REGS); i++) sw_q[i] <= '0;
         for (int i = 0; i < int'(NUM_COUNTERS); i++) cnt_q[i] <= '0;
      end else begin
         reg_req_out     <= reg_req_in;
         reg_ack_out     <= reg_ack_in || claim;
         reg_rd_wr_L_out <= reg_rd_wr_L_in;
         reg_addr_out    <= reg_addr_in;
         reg_src_out     <= reg_src_in;
         reg_data_out    <= (claim && reg_rd_wr_L_in) ? rd_val : reg_data_in;
         for (int i = 0; i < int'(NUM_SOFTWARE_REGS); i++) begin
            if (claim && !reg_rd_wr_L_in && int'(offset) == i) sw_q[i] <= reg_data_in;
         end
         for (int i = 0; i < int'(NUM_COUNTERS); i++) begin
            cnt_q[i] <= cnt_q[i] + CpciDataWidth'(counter_updates[i]);
         end
      end
   end

endmodule

// File: rtl/udp_packet_gate.sv
// Buffers the packet stream and forwards, drops or holds whole packets per the MODE register.
module udp_packet_gate import udp_packet_gate_pkg::*; #(
   parameter int unsigned DATA_WIDTH        = 64,
   parameter int unsigned CTRL_WIDTH        = DATA_WIDTH/8,
   parameter int unsigned UDP_REG_SRC_WIDTH = 2,
   parameter int unsigned FIFO_DEPTH_BITS   = 3,
   parameter int unsigned TAG               = GateTag,
   parameter int unsigned REG_ADDR_WIDTH    = GateRegAddrWidth
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [DATA_WIDTH-1:0]        in_data,
   input  logic [CTRL_WIDTH-1:0]        in_ctrl,
   input  logic                         in_wr,
   output logic                         in_rdy,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic [CTRL_WIDTH-1:0]        out_ctrl,
   output logic                         out_wr,
   input  logic                         out_rdy,
   input  logic                         reg_req_in,
   input  logic                         reg_ack_in,
   input  logic                         reg_rd_wr_L_in,
   input  logic [UdpRegAddrWidth-1:0]   reg_addr_in,
   input  logic [CpciDataWidth-1:0]     reg_data_in,
   input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in,
   output logic                         reg_req_out,
   output logic                         reg_ack_out,
   output logic                         reg_rd_wr_L_out,
   output logic [UdpRegAddrWidth-1:0]   reg_addr_out,
   output logic [CpciDataWidth-1:0]     reg_data_out,
   output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out
);

   logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_dout;
   logic                             fifo_empty, fifo_nearly_full, fifo_rd_en;
   logic [CpciDataWidth-1:0]         sw_regs;
   logic [1:0]                       mode;
   logic                             unused_mode_bits;
   logic                             head_is_ctrl, eop_rd;
   dec_e                             mode_dec, cur_dec;
   state_e                           state_q;
   dec_e                             dec_q;
   logic                             pass_pulse_q, drop_pulse_q;

   fallthrough_small_fifo #(
      .WIDTH          (CTRL_WIDTH + DATA_WIDTH),
      .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .din         ({in_ctrl, in_data}),
      .wr_en       (in_wr),
      .rd_en       (fifo_rd_en),
      .dout        (fifo_dout),
      .nearly_full (fifo_nearly_full),
      .empty       (fifo_empty)
   );

   generic_regs #(
      .TAG               (TAG),
      .REG_ADDR_WIDTH    (REG_ADDR_WIDTH),
      .REG_SRC_WIDTH     (UDP_REG_SRC_WIDTH),
      .NUM_COUNTERS      (2),
      .NUM_SOFTWARE_REGS (1),
      .NUM_HARDWARE_REGS (0)
   ) u_regs (
      .clk             (clk),
      .reset           (reset),
      .reg_req_in      (reg_req_in),
      .reg_ack_in      (reg_ack_in),
      .reg_rd_wr_L_in  (reg_rd_wr_L_in),
      .reg_addr_in     (reg_addr_in),
      .reg_data_in     (reg_data_in),
      .reg_src_in      (reg_src_in),
      .reg_req_out     (reg_req_out),
      .reg_ack_out     (reg_ack_out),
      .reg_rd_wr_L_out (reg_rd_wr_L_out),
      .reg_addr_out    (reg_addr_out),
      .reg_data_out    (reg_data_out),
      .reg_src_out     (reg_src_out),
      .counter_updates ({drop_pulse_q, pass_pulse_q}),
      .software_regs   (sw_regs)
   );

   assign mode             = sw_regs[RegMode*CpciDataWidth +: 2];
   assign unused_mode_bits = ^sw_regs[CpciDataWidth-1:2];
   assign mode_dec         = mode_to_dec(mode);
   assign {out_ctrl, out_data} = fifo_dout;
   assign in_rdy           = !fifo_nearly_full;
   assign head_is_ctrl     = (out_ctrl != '0);

   // Between packets the live mode decides the head word; inside a packet the latched one does.
   assign cur_dec = (state_q == StIdle) ? mode_dec : dec_q;

   always_comb begin
      fifo_rd_en = 1'b0;
      out_wr     = 1'b0;
      case (cur_dec)
         DecPass: begin
            fifo_rd_en = !fifo_empty && out_rdy;
            out_wr     = !fifo_empty && out_rdy;
         end
         DecDrop: fifo_rd_en = !fifo_empty;
         default: begin
            fifo_rd_en = 1'b0;
            out_wr     = 1'b0;
         end
      endcase
   end

   assign eop_rd = fifo_rd_en && (state_q == StPay) && head_is_ctrl;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         dec_q        <= DecPass;
         pass_pulse_q <= 1'b0;
         drop_pulse_q <= 1'b0;
      end else begin
         pass_pulse_q <= eop_rd && (dec_q == DecPass);
         drop_pulse_q <= eop_rd && (dec_q == DecDrop);
         if (state_q == StIdle && !fifo_empty) dec_q <= mode_dec;
         if (fifo_rd_en) begin
            case (state_q)
               StIdle:  state_q <= head_is_ctrl ? StHdr : StPay;
               StHdr:   if (!head_is_ctrl) state_q <= StPay;
               StPay:   if (head_is_ctrl) state_q <= StIdle;
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule
